// File: rtl/apb_master_arbiter.sv
// ============================================================================
// apb_master_arbiter
// ----------------------------------------------------------------------------
// Shares one APB master port between NREQ internal requesters. A round-robin
// arbiter picks one pending request while the bus is idle, the FSM walks it
// through the APB SETUP and ACCESS phases, and the outcome (read data, slave
// error or pready timeout) is returned to the granted requester as a
// single-cycle completion pulse. A slave that never raises pready is
// abandoned after TIMEOUT+1 ACCESS cycles.
//
// Ports
//   pclk, rst             clock; synchronous active-high reset
//   req_valid/req_write   per-requester request and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address / write data
//   req_ready             one-hot accept pulse (combinational, IDLE only)
//   rsp_valid             one-hot completion pulse
//   rsp_rdata             read data of the last completion (held)
//   rsp_err/rsp_tmo       completion status, pulsed with rsp_valid
//   paddr/pwdata/pwrite   APB request fields
//   psel/penable          APB phase controls
//   prdata/pready/pslverr APB slave response
// ============================================================================
module apb_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 5
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_tmo,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    output logic                     pwrite,
    output logic                     psel,
    output logic                     penable,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_write;
    logic               r_psel;
    logic               r_penable;
    logic [NREQ-1:0]    r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rsp_tmo;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic               w_gnt_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [NREQ-1:0]    w_gnt_onehot;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_write;

    // Index of the requester 'offs' places after 'base', wrapping at NREQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search: first valid requester at or after r_ptr.
    // NOTE: every signal assigned in always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = wrap_idx(r_ptr, i);
            if (!w_gnt_found && req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    // Fields of the winning requester, selected without a variable part-select.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_write = req_write[i];
            end
        end
    end

    assign w_ptr_next   = (w_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_onehot = NREQ'(1) << r_gnt;

    // Accept is combinational so a requester sees req_ready in the same cycle
    // the grant is made; it is held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_gnt_found) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_wait      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // Completion status is a one-cycle pulse unless set below.
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_gnt   <= w_gnt_idx;
                        r_ptr   <= w_ptr_next;
                        r_addr  <= w_sel_addr;
                        r_write <= w_sel_write;
                        r_wdata <= w_sel_write ? w_sel_wdata : '0;
                        r_psel  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_gnt_onehot;
                        r_rsp_err   <= pslverr;
                        r_rsp_rdata <= r_write ? '0 : prdata;
                        r_state     <= S_IDLE;
                    end else if (r_wait == CNT_W'(TIMEOUT)) begin
                        // Slave never answered: abort and report a timeout.
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_gnt_onehot;
                        r_rsp_err   <= 1'b1;
                        r_rsp_tmo   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
    assign pwrite    = r_write;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_tmo   = r_rsp_tmo;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// tb_apb_master_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for apb_master_arbiter: a table of single transfers,
// hand-written sequences for arbitration, dropped requests and reset during
// a transfer, then a randomized run compared cycle by cycle against a
// transaction-level model of the arbiter.
// ============================================================================
module tb_apb_master_arbiter;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 5;

    logic                    pclk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_write;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*DATA_W-1:0]  req_wdata;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_tmo;
    logic [ADDR_W-1:0]       paddr;
    logic [DATA_W-1:0]       pwdata;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [DATA_W-1:0]       prdata;
    logic                    pready;
    logic                    pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // access cycle with pready=1; > TIMEOUT never
        logic [31:0] prdata;
        bit          slverr;
        logic [31:0] exp_pwdata;
        bit          exp_err;
        bit          exp_tmo;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic sample();
        @(negedge pclk);
    endtask

    task automatic set_req(input int i, input bit v, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[i] = v;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W]  = addr;
        req_wdata[i*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    // Let any transfer in flight finish with an immediate pready.
    task automatic drain();
        req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            pready = psel & penable;
            next_cycle();
        end
        pready = 1'b0;
    endtask

    // One isolated transfer with full phase-by-phase timing checks.
    task automatic run_vec(input vec_t v, input string tag);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << v.who;
        // T0: accept; pready/pslverr noise in IDLE must be ignored
        req_valid = '0;
        set_req(v.who, 1'b1, v.wr, v.addr, v.wdata);
        pready = 1'b1; pslverr = 1'b1; prdata = '1;
        sample();
        check({tag, ".ready"}, req_ready, oh);
        check({tag, ".psel_t0"}, psel, 0);
        next_cycle();
        // T1: SETUP, more noise on pready
        req_valid = '0;
        sample();
        check({tag, ".psel_t1"}, psel, 1);
        check({tag, ".pen_t1"}, penable, 0);
        check({tag, ".paddr"}, paddr, v.addr);
        check({tag, ".pwrite"}, pwrite, v.wr);
        check({tag, ".pwdata"}, pwdata, v.exp_pwdata);
        next_cycle();
        // ACCESS cycles 0..TIMEOUT at most
        for (int k = 0; k <= TIMEOUT; k++) begin
            pready  = (k == v.waits);
            pslverr = v.slverr;
            prdata  = (k == v.waits) ? v.prdata : ~v.prdata;
            sample();
            check($sformatf("%s.pen_acc%0d", tag, k), {psel, penable}, 2'b11);
            check($sformatf("%s.norsp_acc%0d", tag, k), rsp_valid, 0);
            check($sformatf("%s.paddr_acc%0d", tag, k), paddr, v.addr);
            next_cycle();
            if (k == v.waits) break;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        sample();
        check({tag, ".rsp_valid"}, rsp_valid, oh);
        check({tag, ".rsp_err"}, rsp_err, v.exp_err);
        check({tag, ".rsp_tmo"}, rsp_tmo, v.exp_tmo);
        check({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, ".psel_done"}, {psel, penable}, 2'b00);
        next_cycle();
        sample();
        check({tag, ".pulse_end"}, {rsp_valid, rsp_err, rsp_tmo}, 0);
        check({tag, ".rdata_hold"}, rsp_rdata, v.exp_rdata);
        next_cycle();
    endtask

    // Both requesters held valid: grants alternate and start every 3 cycles.
    task automatic round_robin();
        int acc;
        int cyc;
        int cyc_at[4];
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h100, 32'h1111);
        set_req(1, 1'b1, 1'b0, 32'h200, 32'h2222);
        acc = 0;
        cyc = 0;
        while (acc < 4 && cyc < 40) begin
            pready = psel & penable; pslverr = 1'b0; prdata = 32'h0;
            sample();
            if (req_ready != '0) begin
                check($sformatf("rr.grant%0d", acc), req_ready, (acc % 2 == 0) ? 2'b01 : 2'b10);
                cyc_at[acc] = cyc;
                acc++;
            end
            next_cycle();
            cyc++;
        end
        check("rr.accepts", acc, 4);
        for (int i = 1; i < acc; i++) begin
            check($sformatf("rr.spacing%0d", i), cyc_at[i] - cyc_at[i-1], 3);
        end
        drain();
    endtask

    // A requester raising and dropping valid while busy gets no transfer.
    task automatic drop_seq();
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h60, 32'h66);
        sample();
        check("drop.acc0", req_ready, 2'b01);
        next_cycle();
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 32'h70, 32'h0);
        sample();
        check("drop.busy_setup", req_ready, 0);
        next_cycle();
        req_valid = '0;
        pready = 1'b1;
        sample();
        check("drop.busy_access", req_ready, 0);
        next_cycle();
        pready = 1'b0;
        sample();
        check("drop.rsp0", rsp_valid, 2'b01);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
            check($sformatf("drop.idle%0d", i), {psel, req_ready}, 0);
        end
        next_cycle();
    endtask

    // Reset during ACCESS with req1 pending: bus drops, no response, and the
    // pointer returns to requester 0.
    task automatic reset_mid_seq();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
        sample();
        check("rstm.acc0", req_ready, 2'b01);
        next_cycle();
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 32'h54, 32'h5454);
        sample();
        check("rstm.busy", req_ready, 0);
        next_cycle();
        sample();
        check("rstm.access", {psel, penable}, 2'b11);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        sample();
        check("rstm.bus_off", {psel, penable}, 2'b00);
        check("rstm.no_rsp", rsp_valid, 0);
        check("rstm.no_ready", req_ready, 0);
        next_cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h58, 32'h5858);
        sample();
        check("rstm.no_rsp2", rsp_valid, 0);
        check("rstm.first_grant", req_ready, 2'b01);
        next_cycle();
        drain();
    endtask

    // Randomized run against a transaction-level model: each accepted request
    // is given a planned wait count, from which the whole timeline of the
    // transfer (SETUP, ACCESS span, response cycle and content) follows.
    task automatic random_phase(input int cycles);
        bit                rq_v[NREQ];
        bit                rq_w[NREQ];
        logic [ADDR_W-1:0] rq_a[NREQ];
        logic [DATA_W-1:0] rq_d[NREQ];
        int                last_g, m_ptr, m_acc, m_done, m_w, m_who, c, r;
        bit                m_active, m_write, m_err_plan, in_access;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wdata, m_prdata, m_rdata;
        logic [NREQ-1:0]   e_ready, e_valid;
        bit                e_err, e_tmo, e_psel, e_pen;
        logic [DATA_W-1:0] e_rdata;

        last_g = -1; m_ptr = 0; m_acc = 0; m_done = 0; m_w = 0; m_who = 0;
        m_active = 1'b0; m_write = 1'b0; m_err_plan = 1'b0;
        m_addr = '0; m_wdata = '0; m_prdata = '0; m_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_v[i] = 1'b0; rq_w[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0;
        end

        for (int n = 0; n < cycles; n++) begin
            // requesters: accepted one retires, others may drop or start
            for (int i = 0; i < NREQ; i++) begin
                if (last_g == i) begin
                    rq_v[i] = 1'b0;
                end else if (rq_v[i] && $urandom_range(15) == 0) begin
                    rq_v[i] = 1'b0;
                end else if (!rq_v[i] && $urandom_range(2) == 0) begin
                    rq_v[i] = 1'b1;
                    rq_w[i] = 1'($urandom_range(1));
                    rq_a[i] = $urandom;
                    rq_d[i] = $urandom;
                end
                set_req(i, rq_v[i], rq_w[i], rq_a[i], rq_d[i]);
            end
            last_g = -1;

            // slave: answer on the planned access cycle, noise outside ACCESS
            in_access = m_active && (n >= m_acc + 2);
            if (in_access && (n == m_acc + 2 + m_w)) begin
                pready = 1'b1; pslverr = m_err_plan; prdata = $urandom; m_prdata = prdata;
            end else if (in_access) begin
                pready = 1'b0; pslverr = 1'($urandom_range(1)); prdata = $urandom;
            end else begin
                pready = 1'($urandom_range(1)); pslverr = 1'($urandom_range(1)); prdata = $urandom;
            end

            // expected outputs for this cycle
            e_ready = '0; e_valid = '0; e_err = 1'b0; e_tmo = 1'b0; e_rdata = m_rdata;
            if (m_active && n == m_done) begin
                e_valid = NREQ'(1) << m_who;
                if (m_w <= TIMEOUT) begin
                    e_err   = m_err_plan;
                    e_rdata = m_write ? '0 : m_prdata;
                end else begin
                    e_err = 1'b1; e_tmo = 1'b1; e_rdata = '0;
                end
                m_rdata  = e_rdata;
                m_active = 1'b0;
            end
            e_psel = m_active && (n > m_acc);
            e_pen  = m_active && (n >= m_acc + 2);
            if (!m_active) begin
                for (int j = 0; j < NREQ; j++) begin
                    c = (m_ptr + j) % NREQ;
                    if (last_g < 0 && rq_v[c]) last_g = c;
                end
                if (last_g >= 0) begin
                    e_ready    = NREQ'(1) << last_g;
                    m_active   = 1'b1;
                    m_acc      = n;
                    m_who      = last_g;
                    m_write    = rq_w[last_g];
                    m_addr     = rq_a[last_g];
                    m_wdata    = rq_d[last_g];
                    m_err_plan = ($urandom_range(3) == 0);
                    r = $urandom_range(9);
                    m_w = (r < 4) ? 0 : (r < 8) ? int'($urandom_range(TIMEOUT, 1)) : TIMEOUT + 1;
                    m_done = n + 3 + ((m_w < TIMEOUT) ? m_w : TIMEOUT);
                    m_ptr  = (last_g + 1) % NREQ;
                end
            end

            sample();
            check("rnd.req_ready", req_ready, e_ready);
            check("rnd.rsp_valid", rsp_valid, e_valid);
            check("rnd.rsp_err", rsp_err, e_err);
            check("rnd.rsp_tmo", rsp_tmo, e_tmo);
            check("rnd.rsp_rdata", rsp_rdata, e_rdata);
            check("rnd.psel", psel, e_psel);
            check("rnd.penable", penable, e_pen);
            if (e_psel) begin
                check("rnd.paddr", paddr, m_addr);
                check("rnd.pwrite", pwrite, m_write);
                check("rnd.pwdata", pwdata, m_write ? m_wdata : '0);
            end
            next_cycle();
        end
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h1234_5678, 1'b0,
                    32'hA5A5_0001, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h20, 32'h0000_0055, 3, 32'hDEAD_BEEF, 1'b0,
                    32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{0, 1'b0, 32'h30, 32'h0000_0077, 99, 32'h0000_CAFE, 1'b0,
                    32'h0, 1'b1, 1'b1, 32'h0};
        vecs[3] = '{1, 1'b1, 32'h40, 32'h0BAD_F00D, 1, 32'h4444_4444, 1'b1,
                    32'h0BAD_F00D, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{0, 1'b0, 32'h44, 32'h0000_0000, TIMEOUT, 32'h1357_9BDF, 1'b0,
                    32'h0, 1'b0, 1'b0, 32'h1357_9BDF};
        vecs[5] = '{1, 1'b0, 32'h48, 32'h0000_0099, 2, 32'hFFFF_0000, 1'b1,
                    32'h0, 1'b1, 1'b0, 32'hFFFF_0000};

        // reset values, with requests present to show req_ready stays low
        rst = 1'b1;
        req_valid = '1; req_write = '1; req_addr = '1; req_wdata = '1;
        pready = 1'b1; pslverr = 1'b1; prdata = '1;
        repeat (2) next_cycle();
        sample();
        check("reset.psel", psel, 0);
        check("reset.penable", penable, 0);
        check("reset.pwrite", pwrite, 0);
        check("reset.req_ready", req_ready, 0);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_err", rsp_err, 0);
        check("reset.rsp_tmo", rsp_tmo, 0);
        check("reset.paddr", paddr, 0);
        check("reset.pwdata", pwdata, 0);
        check("reset.rsp_rdata", rsp_rdata, 0);
        next_cycle();
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        round_robin();
        drop_seq();
        reset_mid_seq();

        do_reset();
        random_phase(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
